// File: rtl/seq_gen_if.sv
// Request/status bundle between a serial pattern source and its controller.
// The controller drives the request side and the generator drives the serial/status side.
interface seq_gen_if #(
    parameter int unsigned PAT_W = 7,
    parameter int unsigned RPT_W = 8
);
    localparam int unsigned LEN_W = $clog2(PAT_W + 1);

    logic             start;
    logic             abort;
    logic [PAT_W-1:0] pat_in;
    logic [LEN_W-1:0] pat_len;
    logic [RPT_W-1:0] rpt;
    logic             seq_out;
    logic             seq_vld;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, pat_in, pat_len, rpt,
        input  seq_out, seq_vld, busy, done
    );

    modport slave (
        input  start, abort, pat_in, pat_len, rpt,
        output seq_out, seq_vld, busy, done
    );
endinterface

// File: rtl/seq_gen_fsm.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first, optionally repeated.
// Define SEQ_GEN_GAP_EN to insert GAP_CYC idle cycles between repetitions.
module seq_gen_fsm #(
    parameter int unsigned PAT_W   = 7,
    parameter int unsigned RPT_W   = 8,
    parameter int unsigned GAP_CYC = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    seq_gen_if.slave  sg
);
    localparam int unsigned LEN_W = $clog2(PAT_W + 1);
    localparam int unsigned IDX_W = $clog2(PAT_W);
`ifdef SEQ_GEN_GAP_EN
    localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
`endif

    if (PAT_W < 2 || GAP_CYC < 1) begin : g_param_chk
        $error("seq_gen_fsm: PAT_W must be >= 2 and GAP_CYC >= 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1
`ifdef SEQ_GEN_GAP_EN
       ,GAP  = 2'd2
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [IDX_W-1:0] len_m1_q, len_m1_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [RPT_W-1:0] rpt_q, rpt_d;
`ifdef SEQ_GEN_GAP_EN
    logic [GAP_W-1:0] gap_q, gap_d;
`endif
    logic             seq_out_q, seq_out_d;
    logic             seq_vld_q, seq_vld_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [IDX_W-1:0] acc_len_m1_c;

    // Out-of-range lengths (0 or above PAT_W) fall back to the full pattern width.
    always_comb begin
        if (sg.pat_len == '0 || sg.pat_len > LEN_W'(PAT_W)) begin
            acc_len_m1_c = IDX_W'(PAT_W - 1);
        end else begin
            acc_len_m1_c = IDX_W'(sg.pat_len - LEN_W'(1));
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pat_q     <= '0;
            len_m1_q  <= '0;
            idx_q     <= '0;
            rpt_q     <= '0;
`ifdef SEQ_GEN_GAP_EN
            gap_q     <= '0;
`endif
            seq_out_q <= 1'b0;
            seq_vld_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            len_m1_q  <= len_m1_d;
            idx_q     <= idx_d;
            rpt_q     <= rpt_d;
`ifdef SEQ_GEN_GAP_EN
            gap_q     <= gap_d;
`endif
            seq_out_q <= seq_out_d;
            seq_vld_q <= seq_vld_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next state and next registered outputs; outputs default to the idle values.
    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        len_m1_d  = len_m1_q;
        idx_d     = idx_q;
        rpt_d     = rpt_q;
`ifdef SEQ_GEN_GAP_EN
        gap_d     = gap_q;
`endif
        seq_out_d = 1'b0;
        seq_vld_d = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (sg.start && !sg.abort) begin
                    state_d   = SEND;
                    pat_d     = sg.pat_in;
                    len_m1_d  = acc_len_m1_c;
                    idx_d     = acc_len_m1_c;
                    rpt_d     = sg.rpt;
                    seq_out_d = sg.pat_in[acc_len_m1_c];
                    seq_vld_d = 1'b1;
                    busy_d    = 1'b1;
                end
            end

            SEND: begin
                if (sg.abort) begin
                    state_d = IDLE;
                end else if (idx_q != '0) begin
                    idx_d     = idx_q - IDX_W'(1);
                    seq_out_d = pat_q[idx_d];
                    seq_vld_d = 1'b1;
                    busy_d    = 1'b1;
                end else if (rpt_q != '0) begin
                    // Counting down the latched repeat value gives rpt+1 sends without wrap.
                    rpt_d  = rpt_q - RPT_W'(1);
                    busy_d = 1'b1;
`ifdef SEQ_GEN_GAP_EN
                    state_d = GAP;
                    gap_d   = GAP_W'(GAP_CYC - 1);
`else
                    idx_d     = len_m1_q;
                    seq_out_d = pat_q[len_m1_q];
                    seq_vld_d = 1'b1;
`endif
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end

`ifdef SEQ_GEN_GAP_EN
            GAP: begin
                if (sg.abort) begin
                    state_d = IDLE;
                end else if (gap_q == '0) begin
                    state_d   = SEND;
                    idx_d     = len_m1_q;
                    seq_out_d = pat_q[len_m1_q];
                    seq_vld_d = 1'b1;
                    busy_d    = 1'b1;
                end else begin
                    gap_d  = gap_q - GAP_W'(1);
                    busy_d = 1'b1;
                end
            end
`endif

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sg.seq_out = seq_out_q;
    assign sg.seq_vld = seq_vld_q;
    assign sg.busy    = busy_q;
    assign sg.done    = done_q;

endmodule

// File: tb/tb_seq_gen_fsm.sv
// Self-checking bench for seq_gen_fsm: vector table, hand-written corner sequences,
// and randomized transfers checked against a cycle-list reference model.
module tb_seq_gen_fsm;
    localparam int unsigned PAT_W   = 7;
    localparam int unsigned RPT_W   = 8;
    localparam int unsigned GAP_CYC = 2;
    localparam int unsigned LEN_W   = $clog2(PAT_W + 1);
`ifdef SEQ_GEN_GAP_EN
    localparam bit GAP_ON = 1'b1;
`else
    localparam bit GAP_ON = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_gen_if #(.PAT_W(PAT_W), .RPT_W(RPT_W)) sg ();

    seq_gen_fsm #(.PAT_W(PAT_W), .RPT_W(RPT_W), .GAP_CYC(GAP_CYC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sg    (sg.slave)
    );

    typedef struct packed {
        logic vld;
        logic out;
        logic busy;
        logic done;
    } obs_t;

    typedef struct {
        string            name;
        logic [PAT_W-1:0] pat;
        logic [LEN_W-1:0] len;
        logic [RPT_W-1:0] rpt;
        int               exp_nvld;
        logic [15:0]      exp_bits;
    } vec_t;

    int   tests = 0;
    int   fails = 0;
    obs_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int eff_len(input logic [LEN_W-1:0] len);
        if (len == '0 || int'(len) > int'(PAT_W)) return int'(PAT_W);
        return int'(len);
    endfunction

    // Expected observation per cycle, starting with the cycle after the start edge.
    task automatic build_expect(input logic [PAT_W-1:0] pat, input logic [LEN_W-1:0] len,
                                input logic [RPT_W-1:0] rpt, input int abort_at);
        int l;
        int nb;
        l = eff_len(len);
        exp_q.delete();
        for (int r = 0; r <= int'(rpt); r++) begin
            for (int i = l - 1; i >= 0; i--) exp_q.push_back('{1'b1, pat[i], 1'b1, 1'b0});
            if (GAP_ON && r < int'(rpt))
                for (int g = 0; g < int'(GAP_CYC); g++) exp_q.push_back('{1'b0, 1'b0, 1'b1, 1'b0});
        end
        nb = exp_q.size();
        if (abort_at >= 0 && abort_at < nb) begin
            while (exp_q.size() > abort_at + 1) void'(exp_q.pop_back());
            exp_q.push_back('{1'b0, 1'b0, 1'b0, 1'b0});
        end else begin
            exp_q.push_back('{1'b0, 1'b0, 1'b0, 1'b1});
        end
        exp_q.push_back('{1'b0, 1'b0, 1'b0, 1'b0});
    endtask

    function automatic int model_busy();
        int n = 0;
        foreach (exp_q[i]) if (exp_q[i].busy) n++;
        return n;
    endfunction

    // Cycle-exact transfer; noisy keeps start high with different inputs while busy.
    task automatic run_model(input string tag, input logic [PAT_W-1:0] pat,
                             input logic [LEN_W-1:0] len, input logic [RPT_W-1:0] rpt,
                             input int abort_at, input bit noisy);
        obs_t o;
        build_expect(pat, len, rpt, abort_at);
        sg.pat_in = pat; sg.pat_len = len; sg.rpt = rpt;
        sg.start = 1'b1; sg.abort = 1'b0;
        tick();
        for (int i = 0; i < exp_q.size(); i++) begin
            o = '{sg.seq_vld, sg.seq_out, sg.busy, sg.done};
            chk($sformatf("%s[%0d] {vld,out,busy,done}", tag, i), 32'(o), 32'(exp_q[i]));
            sg.start = noisy && exp_q[i].busy;
            if (noisy) begin
                sg.pat_in  = ~pat;
                sg.pat_len = LEN_W'(2);
                sg.rpt     = RPT_W'(5);
            end
            sg.abort = (i == abort_at);
            tick();
        end
        sg.start = 1'b0;
        sg.abort = 1'b0;
    endtask

    // Collect valid bits until the done pulse, then check counts and pulse width.
    task automatic run_collect(input vec_t v);
        int          nvld  = 0;
        int          nbusy = 0;
        int          cyc   = 0;
        bit          fin   = 1'b0;
        logic [15:0] bits  = '0;
        build_expect(v.pat, v.len, v.rpt, -1);
        sg.pat_in = v.pat; sg.pat_len = v.len; sg.rpt = v.rpt;
        sg.start = 1'b1; sg.abort = 1'b0;
        tick();
        sg.start = 1'b0;
        chk({v.name, " first-cycle vld"}, 32'(sg.seq_vld), 32'd1);
        while (!fin && cyc < 4000) begin
            if (sg.seq_vld) begin
                nvld++;
                bits = {bits[14:0], sg.seq_out};
            end
            if (sg.busy) nbusy++;
            if (sg.done) fin = 1'b1;
            else tick();
            cyc++;
        end
        chk({v.name, " done seen"}, 32'(fin), 32'd1);
        chk({v.name, " valid count"}, 32'(nvld), 32'(v.exp_nvld));
        chk({v.name, " bit stream"}, 32'(bits), 32'(v.exp_bits));
        chk({v.name, " busy cycles"}, 32'(nbusy), 32'(model_busy()));
        tick();
        chk({v.name, " done width"}, 32'(sg.done), 32'd0);
    endtask

    task automatic wait_idle(input string name);
        int cyc = 0;
        while (sg.busy && cyc < 4000) begin
            tick();
            cyc++;
        end
        chk({name, " returned idle"}, 32'(sg.busy), 32'd0);
    endtask

    vec_t tbl[6];

    initial begin
        tbl[0] = '{"p7r0",   7'b1011010, LEN_W'(7), RPT_W'(0),   7,   16'b1011010};
        tbl[1] = '{"p7r1",   7'b1011010, LEN_W'(7), RPT_W'(1),   14,  16'b10110101011010};
        tbl[2] = '{"p3r2",   7'b0000101, LEN_W'(3), RPT_W'(2),   9,   16'b101101101};
        tbl[3] = '{"len0",   7'b0000101, LEN_W'(0), RPT_W'(0),   7,   16'b0000101};
        tbl[4] = '{"len1r3", 7'b0000001, LEN_W'(1), RPT_W'(3),   4,   16'b1111};
        tbl[5] = '{"rptmax", 7'b1111110, LEN_W'(2), RPT_W'(255), 512, 16'b1010101010101010};

        sg.start = 1'b0; sg.abort = 1'b0;
        sg.pat_in = '0; sg.pat_len = '0; sg.rpt = '0;
        repeat (2) tick();
        chk("reset seq_vld", 32'(sg.seq_vld), 32'd0);
        chk("reset seq_out", 32'(sg.seq_out), 32'd0);
        chk("reset busy",    32'(sg.busy),    32'd0);
        chk("reset done",    32'(sg.done),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // abort wins over start in IDLE; lone abort in IDLE does nothing
        sg.pat_in = 7'b1011010; sg.pat_len = LEN_W'(7); sg.rpt = '0;
        sg.start = 1'b1; sg.abort = 1'b1;
        tick();
        chk("start+abort idle busy", 32'(sg.busy), 32'd0);
        chk("start+abort idle vld",  32'(sg.seq_vld), 32'd0);
        sg.start = 1'b0;
        tick();
        chk("abort idle busy", 32'(sg.busy), 32'd0);
        sg.abort = 1'b0;

        for (int i = 0; i < 6; i++) run_collect(tbl[i]);

        // start held during the transfer is ignored; abort on the fifth bit ends it
        run_model("busy-start+abort", 7'b1011010, LEN_W'(7), RPT_W'(0), 4, 1'b1);
        run_collect(tbl[0]);

        // asynchronous reset mid-transfer
        sg.pat_in = 7'b1011010; sg.pat_len = LEN_W'(7); sg.rpt = RPT_W'(1);
        sg.start = 1'b1;
        tick();
        sg.start = 1'b0;
        repeat (2) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst vld",  32'(sg.seq_vld), 32'd0);
        chk("async rst busy", 32'(sg.busy),    32'd0);
        chk("async rst out",  32'(sg.seq_out), 32'd0);
        chk("async rst done", 32'(sg.done),    32'd0);
        #4;
        rst_n = 1'b1;
        tick();
        chk("post rst busy", 32'(sg.busy), 32'd0);
        chk("post rst done", 32'(sg.done), 32'd0);
        run_collect(tbl[2]);

        // start presented in the done cycle is accepted
        sg.pat_in = 7'b0000001; sg.pat_len = LEN_W'(1); sg.rpt = '0;
        sg.start = 1'b1;
        tick();
        sg.start = 1'b0;
        chk("len1 bit", 32'(sg.seq_out), 32'd1);
        tick();
        chk("len1 done", 32'(sg.done), 32'd1);
        sg.pat_in = 7'b0011010; sg.pat_len = LEN_W'(7);
        sg.start = 1'b1;
        tick();
        sg.start = 1'b0;
        chk("restart in done vld",  32'(sg.seq_vld), 32'd1);
        chk("restart in done out",  32'(sg.seq_out), 32'd0);
        chk("restart in done done", 32'(sg.done),    32'd0);
        wait_idle("restart in done");
        tick();

        // randomized transfers against the model
        for (int n = 0; n < 40; n++) begin
            logic [PAT_W-1:0] pat;
            logic [LEN_W-1:0] len;
            logic [RPT_W-1:0] rpt;
            int               nb;
            int               ab;
            pat = PAT_W'($urandom());
            len = LEN_W'($urandom_range(0, PAT_W));
            rpt = RPT_W'($urandom_range(0, 3));
            nb  = eff_len(len) * (int'(rpt) + 1) + (GAP_ON ? int'(GAP_CYC) * int'(rpt) : 0);
            ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
            run_model($sformatf("rnd%0d", n), pat, len, rpt, ab, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
